// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits (LSB first),
// optional odd/even parity, 1..2 stop bits. One word per valid/ready transfer.
module uart_tx_cfg #(
    parameter int CLOCK_SPEED = 50_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DATA_BITS-1:0] s_data,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int BAUD_DIV = CLOCK_SPEED / BAUD_RATE;
    localparam int CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || BAUD_DIV < 2) begin : g_cfg_error
        $error("uart_tx_cfg: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [3:0]            bit_q, bit_d;
    logic                  stop_q, stop_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;

    logic                  accept;
    logic                  baud_tc;
    logic                  last_bit;
    logic                  last_stop;
    logic [DATA_BITS-1:0]  shift_next;

    assign accept     = s_valid && (state_q == S_IDLE);
    assign baud_tc    = (cnt_q == CNT_W'(BAUD_DIV - 1));
    assign last_bit   = (bit_q == 4'(DATA_BITS - 1));
    assign last_stop  = (stop_q == 1'(STOP_BITS - 1));
    assign shift_next = shift_q >> 1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; tx resets high asynchronously so a mid-frame
    // reset releases the line immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (accept) state_d = S_START;
            S_START:  if (baud_tc) state_d = S_DATA;
            S_DATA:   if (baud_tc && last_bit) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (baud_tc) state_d = S_STOP;
            S_STOP:   if (baud_tc && last_stop) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Each bit's line value is computed one edge ahead so tx stays a flop.
    always_comb begin
        cnt_d   = baud_tc ? '0 : cnt_q + 1'b1;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (accept) begin
                    shift_d = s_data;
                    par_d   = (PARITY == 2) ? ^s_data : ~^s_data;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (baud_tc) begin
                    tx_d  = shift_q[0];
                    bit_d = '0;
                end
            end
            S_DATA: begin
                if (baud_tc) begin
                    if (last_bit) begin
                        bit_d  = '0;
                        stop_d = 1'b0;
                        tx_d   = (PARITY != 0) ? par_q : 1'b1;
                    end else begin
                        shift_d = shift_next;
                        tx_d    = shift_next[0];
                        bit_d   = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (baud_tc) begin
                    tx_d   = 1'b1;
                    stop_d = 1'b0;
                end
            end
            S_STOP: begin
                if (baud_tc) begin
                    tx_d = 1'b1;
                    if (last_stop) done_d = 1'b1;
                    else           stop_d = stop_q + 1'b1;
                end
            end
            default: tx_d = 1'b1;
        endcase
    end

    assign s_ready = (state_q == S_IDLE);
    assign busy    = (state_q != S_IDLE);
    assign tx      = tx_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: four configurations (8N1, 8E1, 8O1, 7O2),
// all with BAUD_DIV = 8, checked cycle by cycle against hand-built bit lists.
module tb_uart_tx_cfg;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [3:0]      sv = '0;
    logic [3:0][8:0] sd = '0;
    wire  [3:0]      rdy, txl, bsy, dn;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.CLOCK_SPEED(800), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .s_valid(sv[0]), .s_ready(rdy[0]), .s_data(sd[0][7:0]),
        .tx(txl[0]), .busy(bsy[0]), .tx_done(dn[0]));
    uart_tx_cfg #(.CLOCK_SPEED(800), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst_n(rst_n), .s_valid(sv[1]), .s_ready(rdy[1]), .s_data(sd[1][7:0]),
        .tx(txl[1]), .busy(bsy[1]), .tx_done(dn[1]));
    uart_tx_cfg #(.CLOCK_SPEED(800), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst_n(rst_n), .s_valid(sv[2]), .s_ready(rdy[2]), .s_data(sd[2][7:0]),
        .tx(txl[2]), .busy(bsy[2]), .tx_done(dn[2]));
    uart_tx_cfg #(.CLOCK_SPEED(800), .BAUD_RATE(100), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7o2 (
        .clk(clk), .rst_n(rst_n), .s_valid(sv[3]), .s_ready(rdy[3]), .s_data(sd[3][6:0]),
        .tx(txl[3]), .busy(bsy[3]), .tx_done(dn[3]));

    // Present a word while idle; returns just after the accepting edge.
    task automatic offer(input int u, input logic [8:0] data, input string name);
        @(negedge clk);
        checks++;
        if (rdy[u] !== 1'b1) begin
            failures++;
            $display("FAIL %s ready before accept: got %b want 1", name, rdy[u]);
        end
        sv[u] = 1'b1;
        sd[u] = data;
        @(posedge clk);
    endtask

    // Checks every cycle of one frame after its accept edge, then the
    // first IDLE cycle (tx_done pulse, ready back).
    task automatic expect_frame(input int u, input logic [8:0] data, input int nbits,
                                input int par, input int nstop, input bit hold,
                                input int chg_at, input logic [8:0] chg_val, input string name);
        logic exp_bits[16];
        int   nb;
        logic p;
        p = 1'b0;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            exp_bits[1 + i] = data[i];
            p = p ^ data[i];
        end
        nb = 1 + nbits;
        if (par != 0) begin
            exp_bits[nb] = (par == 2) ? p : ~p;
            nb++;
        end
        for (int s = 0; s < nstop; s++) begin
            exp_bits[nb] = 1'b1;
            nb++;
        end
        for (int k = 0; k < nb * 8; k++) begin
            @(negedge clk);
            checks++;
            if (txl[u] !== exp_bits[k / 8] || bsy[u] !== 1'b1 || dn[u] !== 1'b0) begin
                failures++;
                $display("FAIL %s bit%0d cyc%0d: tx=%b busy=%b done=%b want tx=%b busy=1 done=0",
                         name, k / 8, k, txl[u], bsy[u], dn[u], exp_bits[k / 8]);
            end
            if (k == 0 && !hold) sv[u] = 1'b0;
            if (k == chg_at) sd[u] = chg_val;
        end
        @(negedge clk);
        checks++;
        if (dn[u] !== 1'b1 || rdy[u] !== 1'b1 || txl[u] !== 1'b1 || bsy[u] !== 1'b0) begin
            failures++;
            $display("FAIL %s frame end: done=%b ready=%b tx=%b busy=%b want 1 1 1 0",
                     name, dn[u], rdy[u], txl[u], bsy[u]);
        end
    endtask

    task automatic check_idle(input int u, input string name);
        @(negedge clk);
        checks++;
        if (dn[u] !== 1'b0 || txl[u] !== 1'b1 || rdy[u] !== 1'b1) begin
            failures++;
            $display("FAIL %s idle after frame: done=%b tx=%b ready=%b want 0 1 1",
                     name, dn[u], txl[u], rdy[u]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        for (int u = 0; u < 4; u++) begin
            checks++;
            if (txl[u] !== 1'b1 || rdy[u] !== 1'b1 || bsy[u] !== 1'b0 || dn[u] !== 1'b0) begin
                failures++;
                $display("FAIL reset dut%0d: tx=%b ready=%b busy=%b done=%b want 1 1 0 0",
                         u, txl[u], rdy[u], bsy[u], dn[u]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_8n1();
        offer(0, 9'h0A5, "8n1");
        expect_frame(0, 9'h0A5, 8, 0, 1, 1'b0, -1, 9'h0, "8n1");
        check_idle(0, "8n1");
    endtask

    task automatic test_parity();
        offer(1, 9'h0A5, "8e1");
        expect_frame(1, 9'h0A5, 8, 2, 1, 1'b0, -1, 9'h0, "8e1");
        check_idle(1, "8e1");
        offer(2, 9'h0A5, "8o1");
        expect_frame(2, 9'h0A5, 8, 1, 1, 1'b0, -1, 9'h0, "8o1");
        check_idle(2, "8o1");
    endtask

    task automatic test_7o2();
        offer(3, 9'h041, "7o2");
        expect_frame(3, 9'h041, 7, 1, 2, 1'b0, -1, 9'h0, "7o2");
        check_idle(3, "7o2");
    endtask

    task automatic test_back_to_back();
        offer(0, 9'h03C, "b2b_a");
        expect_frame(0, 9'h03C, 8, 0, 1, 1'b1, 20, 9'h0C3, "b2b_a");
        @(posedge clk);
        expect_frame(0, 9'h0C3, 8, 0, 1, 1'b0, 20, 9'h0FF, "b2b_b");
        check_idle(0, "b2b_b");
    endtask

    task automatic test_reset_mid_frame();
        bit stray;
        offer(0, 9'h000, "rst_mid");
        @(negedge clk);
        sv[0] = 1'b0;
        repeat (29) @(negedge clk);
        checks++;
        if (txl[0] !== 1'b0 || bsy[0] !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid in DATA: tx=%b busy=%b want 0 1", txl[0], bsy[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (txl[0] !== 1'b1 || rdy[0] !== 1'b1 || bsy[0] !== 1'b0 || dn[0] !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid during reset: tx=%b ready=%b busy=%b done=%b want 1 1 0 0",
                     txl[0], rdy[0], bsy[0], dn[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stray = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (dn[0] !== 1'b0 || txl[0] !== 1'b1 || rdy[0] !== 1'b1) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            failures++;
            $display("FAIL rst_mid after release: saw done/tx-low/not-ready, want quiet idle");
        end
        offer(0, 9'h055, "rst_next");
        expect_frame(0, 9'h055, 8, 0, 1, 1'b0, -1, 9'h0, "rst_next");
        check_idle(0, "rst_next");
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_7o2();
        test_back_to_back();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
